// File: rtl/pcbranch_unit.sv
// Program-counter sequencer: each cycle it registers either base+STEP or base+OFFSET, chosen by the branch class.
// Optional build macro PCBRANCH_EXT_BASE_EN selects the external PC input as the base instead of the internal register.
module pcbranch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              STEP     = 4
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [XLEN-1:0] PC,
  input  logic [XLEN-1:0] OFFSET,
  input  logic [2:0]      FUNCT_THREE,
  input  logic            Z,
  input  logic            N,
  output logic [XLEN-1:0] NEXTPC
);

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_JUMP = 3'b010,
    BR_NONE = 3'b011,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } br_class_e;

  localparam logic [XLEN-1:0] STEP_W = XLEN'(STEP);

  // Power-up value lets the block sequence correctly with RST_N tied high.
  logic [XLEN-1:0] pc_q = RESET_PC;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] base;
  logic            taken;

`ifdef PCBRANCH_EXT_BASE_EN
  assign base = PC;
`else
  logic unused_pc;
  assign unused_pc = ^PC;
  assign base      = pc_q;
`endif

  // Unsigned compares arrive on N as well, so signed and unsigned pairs decode alike.
  always_comb begin
    taken = 1'b0;
    case (FUNCT_THREE)
      BR_BEQ:  taken = Z;
      BR_BNE:  taken = !Z;
      BR_JUMP: taken = 1'b1;
      BR_NONE: taken = 1'b0;
      BR_BLT:  taken = N;
      BR_BGE:  taken = !N;
      BR_BLTU: taken = N;
      BR_BGEU: taken = !N;
      default: taken = 1'bx;
    endcase
  end

  always_comb begin
    pc_d = base + STEP_W;
    if (taken) begin
      pc_d = base + OFFSET;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign NEXTPC = pc_q;

endmodule

// File: tb/tb_pcbranch_unit.sv
// Scoreboard bench for pcbranch_unit: a directed sequence followed by random branch traffic,
// with expectations from a reference model of the branch rules and a separate monitor comparing NEXTPC.
module tb_pcbranch_unit;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [31:0] OFFSET;
  logic [2:0]  FUNCT_THREE;
  logic        Z;
  logic        N;
  logic [31:0] NEXTPC;

  logic [31:0] exp_q[$];
  int          checks = 0;
  int          passed = 0;
  logic [31:0] model_pc;

  always #5 CLK = ~CLK;

  pcbranch_unit #(.XLEN(32), .RESET_PC(32'h0), .STEP(4)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .PC(NEXTPC),
    .OFFSET(OFFSET),
    .FUNCT_THREE(FUNCT_THREE),
    .Z(Z),
    .N(N),
    .NEXTPC(NEXTPC)
  );

  function automatic bit branch_taken(input logic [2:0] f, input logic zf, input logic nf);
    case (f)
      3'd0: return zf == 1'b1;
      3'd1: return zf == 1'b0;
      3'd2: return 1'b1;
      3'd3: return 1'b0;
      3'd4, 3'd6: return nf == 1'b1;
      default: return nf == 1'b0;
    endcase
  endfunction

  // Reference: reset wins; otherwise the address moves by the displacement or by one word, modulo 2^32.
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic rst,
                                             input logic [2:0] f, input logic zf,
                                             input logic nf, input logic [31:0] off);
    longint unsigned sum;
    if (!rst) return 32'd0;
    sum = longint'(cur) + (branch_taken(f, zf, nf) ? longint'(off) : 64'd4);
    return sum[31:0];
  endfunction

  task automatic drive(input logic rst, input logic [2:0] f, input logic zf, input logic nf,
                       input logic [31:0] off);
    @(negedge CLK);
    RST_N = rst; FUNCT_THREE = f; Z = zf; N = nf; OFFSET = off;
    model_pc = model_next(model_pc, rst, f, zf, nf, off);
    exp_q.push_back(model_pc);
  endtask

  task automatic drive_exp(input logic rst, input logic [2:0] f, input logic zf, input logic nf,
                           input logic [31:0] off, input logic [31:0] want);
    @(negedge CLK);
    RST_N = rst; FUNCT_THREE = f; Z = zf; N = nf; OFFSET = off;
    model_pc = want;
    exp_q.push_back(want);
  endtask

  initial begin : monitor
    logic [31:0] want;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        checks++;
        if (!$isunknown(NEXTPC) && NEXTPC === want) passed++;
        else $display("FAIL nextpc check %0d: got %h expected %h", checks, NEXTPC, want);
      end
    end
  end

  initial begin : stim
    int wait_cycles;
    logic [2:0] f;
    logic [31:0] off;
    model_pc = 32'd0;
    RST_N = 1'b1; FUNCT_THREE = 3'b011; Z = 1'b0; N = 1'b0; OFFSET = 32'd0;

    drive_exp(1'b0, 3'b011, 1'b0, 1'b0, 32'd0, 32'd0);
    drive_exp(1'b1, 3'b011, 1'b0, 1'b0, 32'd0, 32'd4);
    drive_exp(1'b1, 3'b000, 1'b1, 1'b0, 32'd8, 32'd12);
    drive_exp(1'b1, 3'b000, 1'b0, 1'b0, 32'd8, 32'd16);
    drive_exp(1'b1, 3'b001, 1'b0, 1'b0, 32'd8, 32'd24);
    drive_exp(1'b1, 3'b001, 1'b1, 1'b0, 32'd8, 32'd28);
    drive_exp(1'b1, 3'b100, 1'b0, 1'b1, 32'd8, 32'd36);
    drive_exp(1'b1, 3'b100, 1'b1, 1'b0, 32'd8, 32'd40);
    drive_exp(1'b1, 3'b100, 1'b0, 1'b0, 32'd8, 32'd44);
    drive_exp(1'b1, 3'b100, 1'b0, 1'b1, 32'd8, 32'd52);
    drive_exp(1'b1, 3'b101, 1'b0, 1'b0, 32'd8, 32'd60);
    drive_exp(1'b1, 3'b101, 1'b0, 1'b1, 32'd8, 32'd64);
    drive_exp(1'b1, 3'b010, 1'bx, 1'bx, 32'd8, 32'd72);
    drive_exp(1'b1, 3'b010, 1'bx, 1'bx, 32'd12, 32'd84);
    drive_exp(1'b1, 3'b010, 1'b0, 1'b0, 32'd0, 32'd84);
    drive_exp(1'b1, 3'b010, 1'b0, 1'b0, 32'hFFFF_FFA8, 32'hFFFF_FFFC);
    drive_exp(1'b1, 3'b011, 1'b0, 1'b0, 32'd0, 32'd0);
    drive_exp(1'b1, 3'b011, 1'b0, 1'b0, 32'd0, 32'd4);
    drive_exp(1'b1, 3'b011, 1'b0, 1'b0, 32'd0, 32'd8);
    drive_exp(1'b1, 3'b011, 1'b0, 1'b0, 32'd0, 32'd12);
    drive_exp(1'b1, 3'b111, 1'b0, 1'b0, 32'd4, 32'd16);
    drive_exp(1'b1, 3'b010, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'd8);
    drive_exp(1'b1, 3'b110, 1'b0, 1'b1, 32'd64, 32'd72);
    drive_exp(1'b0, 3'b010, 1'b0, 1'b0, 32'd100, 32'd0);
    drive_exp(1'b1, 3'b011, 1'b0, 1'b0, 32'd0, 32'd4);

    for (int i = 0; i < 400; i++) begin
      f = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: off = 32'($urandom_range(0, 255)) << 2;
        1: off = -(32'($urandom_range(1, 255)) << 2);
        2: off = 32'd0;
        default: off = $urandom();
      endcase
      drive(($urandom_range(0, 15) != 0), f, 1'($urandom()), 1'($urandom()), off);
    end

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(negedge CLK);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
